d_cache_nway: RTL and testbench



---
 rtl/d_cache_nway_pkg.sv | 29 ++
 rtl/d_cache_nway_plru_tree.sv | 49 ++++
 rtl/d_cache_nway.sv | 197 +++++++++++++++++++
 tb/tb_d_cache_nway.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_cache_nway_pkg.sv
// Shared types for the N-way data cache: memory bus widths, byte mask,
// controller state encoding and a byte-lane merge helper.
package d_cache_nway_pkg;

    typedef logic [127:0] lc3b_memband;
    typedef logic [1:0]   lc3b_mem_wmask;
    typedef logic [15:0]  lc3b_word;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } d_cache_state_t;

    // Replace the byte lanes of one 16-bit word inside a line.
    function automatic lc3b_memband merge_word(
        input lc3b_memband   line,
        input logic [2:0]    word_sel,
        input lc3b_mem_wmask be,
        input lc3b_word      wdata
    );
        lc3b_memband r;
        r = line;
        if (be[0]) r[{word_sel, 4'b0000} +: 8] = wdata[7:0];
        if (be[1]) r[{word_sel, 4'b1000} +: 8] = wdata[15:8];
        return r;
    endfunction

endpackage

// File: rtl/d_cache_nway_plru_tree.sv
// Tree pseudo-LRU for one set. Node n has children 2n+1 (left) and 2n+2
// (right); a node bit of 0 points the victim search left, 1 points right.
// Purely combinational: victim from current bits, next bits after an access.
module plru_tree #(
    parameter int WAYS = 2
) (
    input  logic [WAYS-2:0]         plru,
    input  logic [$clog2(WAYS)-1:0] access_way,
    output logic [$clog2(WAYS)-1:0] victim,
    output logic [WAYS-2:0]         plru_next
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int PW    = WAYS - 1;

    // Walk from the root following the node bits to find the victim way.
    always_comb begin
        int node;
        int v;
        logic b;
        node = 0;
        v    = 0;
        b    = 1'b0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            b    = |(plru & (PW'(1) << node));
            v    = v * 2 + int'(b);
            node = 2 * node + 1 + int'(b);
        end
        victim = WAY_W'(v);
    end

    // Walk the path of the accessed way, pointing every node the other way.
    always_comb begin
        int node;
        logic dir;
        logic [PW-1:0] mask;
        node      = 0;
        dir       = 1'b0;
        mask      = '0;
        plru_next = plru;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            dir  = 1'(access_way >> (WAY_W - 1 - lvl));
            mask = PW'(1) << node;
            if (dir) plru_next = plru_next & ~mask;
            else     plru_next = plru_next | mask;
            node = 2 * node + 1 + int'(dir);
        end
    end

endmodule

// File: rtl/d_cache_nway.sv
// N-way set-associative write-back, write-allocate data cache between a
// 16-bit CPU port and a 128-bit line port. Hits complete in the request
// cycle; misses optionally write back the victim, then fill it.
// Handshake: CPU holds mem_read/mem_write until the one-cycle mem_resp;
// the cache holds pmem_read/pmem_write until the one-cycle pmem_resp.
module d_cache_nway
    import d_cache_nway_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int SETS  = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          mem_address,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [1:0]           mem_byte_enable,
    input  logic [15:0]          mem_wdata,
    output logic [15:0]          mem_rdata,
    output logic                 mem_resp,
    output logic [15:0]          pmem_address,
    input  logic [127:0]         pmem_rdata,
    output logic [127:0]         pmem_wdata,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    output logic [CNT_W-1:0]     hit_count,
    output logic [CNT_W-1:0]     miss_count,
    output d_cache_state_t       fsm_state
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 12 - IDX_W;
    localparam int WAY_W = $clog2(WAYS);

    d_cache_state_t state, next_state;

    lc3b_memband      data_arr  [WAYS][SETS];
    logic [TAG_W-1:0] tag_arr   [WAYS][SETS];
    logic [WAYS-1:0]  valid_arr [SETS];
    logic [WAYS-1:0]  dirty_arr [SETS];
    logic [WAYS-2:0]  plru_arr  [SETS];

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] idx;
    logic [2:0]       word_sel;
    logic             request;
    logic             addr_unused;

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             has_invalid;
    logic [WAY_W-1:0] first_invalid;
    logic [WAY_W-1:0] plru_victim;
    logic [WAY_W-1:0] victim_sel;
    logic [WAY_W-1:0] victim_q;
    logic [WAYS-2:0]  plru_next;

    logic hit_fire, miss_fire, wb_done, fill_done;

    assign req_tag     = mem_address[15 -: TAG_W];
    assign idx         = mem_address[3+IDX_W:4];
    assign word_sel    = mem_address[3:1];
    assign addr_unused = mem_address[0];
    assign request     = mem_read | mem_write;
    assign fsm_state   = state;

    // Tag compare across all ways, and lowest-numbered invalid way.
    always_comb begin
        logic [WAY_W-1:0] wi;
        hit           = 1'b0;
        hit_way       = '0;
        has_invalid   = 1'b0;
        first_invalid = '0;
        wi            = '0;
        for (int w = 0; w < WAYS; w++) begin
            wi = WAY_W'(w);
            if (valid_arr[idx][wi] && (tag_arr[wi][idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = wi;
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            wi = WAY_W'(w);
            if (!valid_arr[idx][wi]) begin
                has_invalid   = 1'b1;
                first_invalid = wi;
            end
        end
    end

    plru_tree #(.WAYS(WAYS)) u_plru (
        .plru       (plru_arr[idx]),
        .access_way (hit_way),
        .victim     (plru_victim),
        .plru_next  (plru_next)
    );

    assign victim_sel = has_invalid ? first_invalid : plru_victim;

    // Read port: selected word of the hitting line, zero otherwise.
    always_comb begin
        mem_rdata = '0;
        if (hit) mem_rdata = data_arr[hit_way][idx][{word_sel, 4'b0000} +: 16];
    end

    // Controller next-state and bus outputs.
    always_comb begin
        next_state   = state;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        hit_fire     = 1'b0;
        miss_fire    = 1'b0;
        wb_done      = 1'b0;
        fill_done    = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        hit_fire = 1'b1;
                    end else begin
                        miss_fire = 1'b1;
                        if (valid_arr[idx][victim_sel] && dirty_arr[idx][victim_sel])
                            next_state = WRITEBACK;
                        else
                            next_state = FILL;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_arr[victim_q][idx], idx, 4'b0000};
                pmem_wdata   = data_arr[victim_q][idx];
                if (pmem_resp) begin
                    wb_done    = 1'b1;
                    next_state = FILL;
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, idx, 4'b0000};
                if (pmem_resp) begin
                    fill_done  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State, victim latch, valid/dirty/PLRU bookkeeping and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            victim_q   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_arr[IDX_W'(s)] <= '0;
                dirty_arr[IDX_W'(s)] <= '0;
                plru_arr[IDX_W'(s)]  <= '0;
            end
        end else begin
            state <= next_state;
            if (miss_fire) begin
                victim_q <= victim_sel;
                if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
            end
            if (hit_fire) begin
                plru_arr[idx] <= plru_next;
                if (mem_write) dirty_arr[idx][hit_way] <= 1'b1;
                if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
            end
            if (wb_done) dirty_arr[idx][victim_q] <= 1'b0;
            if (fill_done) begin
                valid_arr[idx][victim_q] <= 1'b1;
                dirty_arr[idx][victim_q] <= 1'b0;
            end
        end
    end

    // Line and tag storage: CPU byte writes on hit, whole-line refill.
    always_ff @(posedge clk) begin
        if (hit_fire && mem_write)
            data_arr[hit_way][idx] <= merge_word(data_arr[hit_way][idx], word_sel,
                                                 mem_byte_enable, mem_wdata);
        if (fill_done) begin
            data_arr[victim_q][idx] <= pmem_rdata;
            tag_arr[victim_q][idx]  <= req_tag;
        end
    end

endmodule

// File: tb/tb_d_cache_nway.sv
// Directed bench for d_cache_nway: a 2-way/16-bit-counter instance and a
// 4-way/4-bit-counter instance share CPU stimulus, steered by sel.
module tb_d_cache_nway;
    import d_cache_nway_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] addr;
    logic        rd, wr, sel, stall;
    logic [1:0]  be;
    logic [15:0] wdata;

    logic [15:0] rdata_a, paddr_a, rdata_b, paddr_b;
    logic        resp_a, pread_a, pwrite_a, presp_a;
    logic        resp_b, pread_b, pwrite_b, presp_b;
    lc3b_memband prdata_a, pwdata_a, prdata_b, pwdata_b;
    logic [15:0] hit_a, miss_a;
    logic [3:0]  hit_b, miss_b;
    d_cache_state_t state_a, state_b;

    int n_vec = 0;
    int n_bad = 0;

    int          fill_a = 0, wb_a = 0, fill_b = 0, wb_b = 0;
    logic [15:0] last_fill_a, last_wb_a;
    lc3b_memband wb_data_a;
    logic [16:0] ev_q[$];

    d_cache_nway #(.WAYS(2), .SETS(8), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .mem_address(addr),
        .mem_read(rd & ~sel), .mem_write(wr & ~sel),
        .mem_byte_enable(be), .mem_wdata(wdata), .mem_rdata(rdata_a),
        .mem_resp(resp_a), .pmem_address(paddr_a), .pmem_rdata(prdata_a),
        .pmem_wdata(pwdata_a), .pmem_read(pread_a), .pmem_write(pwrite_a),
        .pmem_resp(presp_a), .hit_count(hit_a), .miss_count(miss_a),
        .fsm_state(state_a)
    );

    d_cache_nway #(.WAYS(4), .SETS(8), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .mem_address(addr),
        .mem_read(rd & sel), .mem_write(wr & sel),
        .mem_byte_enable(be), .mem_wdata(wdata), .mem_rdata(rdata_b),
        .mem_resp(resp_b), .pmem_address(paddr_b), .pmem_rdata(prdata_b),
        .pmem_wdata(pwdata_b), .pmem_read(pread_b), .pmem_write(pwrite_b),
        .pmem_resp(presp_b), .hit_count(hit_b), .miss_count(miss_b),
        .fsm_state(state_b)
    );

    // Backing memory content: word i of line L reads as {L[15:4], 1'b0, i}.
    function automatic lc3b_memband line_of(input logic [15:0] a);
        lc3b_memband l;
        for (int i = 0; i < 8; i++) l[i*16 +: 16] = {a[15:4], 1'b0, 3'(i)};
        return l;
    endfunction

    // Memory model for instance A: answers after two cycles, logs traffic.
    initial begin : mem_model_a
        int cnt;
        cnt = 0; presp_a = 1'b0; prdata_a = '0;
        forever begin
            @(negedge clk);
            if (presp_a) begin
                presp_a = 1'b0; cnt = 0;
            end else if ((pread_a || pwrite_a) && !stall && rst_n) begin
                cnt++;
                if (cnt == 2) begin
                    presp_a = 1'b1;
                    if (pwrite_a) begin
                        wb_a++; last_wb_a = paddr_a; wb_data_a = pwdata_a;
                        ev_q.push_back({1'b1, paddr_a});
                    end else begin
                        fill_a++; last_fill_a = paddr_a; prdata_a = line_of(paddr_a);
                        ev_q.push_back({1'b0, paddr_a});
                    end
                end
            end else cnt = 0;
        end
    end

    // Memory model for instance B.
    initial begin : mem_model_b
        int cnt;
        cnt = 0; presp_b = 1'b0; prdata_b = '0;
        forever begin
            @(negedge clk);
            if (presp_b) begin
                presp_b = 1'b0; cnt = 0;
            end else if ((pread_b || pwrite_b) && rst_n) begin
                cnt++;
                if (cnt == 2) begin
                    presp_b = 1'b1;
                    if (pwrite_b) wb_b++;
                    else begin fill_b++; prdata_b = line_of(paddr_b); end
                end
            end else cnt = 0;
        end
    end

    // One CPU access; lat counts negedges until mem_resp was seen.
    task automatic cpu_access(input bit to_b, input logic [15:0] a, input bit is_wr,
                              input logic [1:0] m, input logic [15:0] d,
                              output logic [15:0] q, output int lat);
        bit got;
        sel = to_b; addr = a; be = m; wdata = d; rd = !is_wr; wr = is_wr;
        lat = 0; q = '0; got = 0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (to_b ? resp_b : resp_a) begin
                got = 1;
                q = to_b ? rdata_b : rdata_a;
            end
        end
        n_vec++;
        if (!got) begin
            n_bad++;
            $display("FAIL resp_timeout addr=%h: no mem_resp within %0d cycles", a, lat);
        end
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rd = 0; wr = 0; sel = 0; stall = 0; addr = '0; be = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (resp_a !== 1'b0) begin n_bad++; $display("FAIL rst_mem_resp got %b want 0", resp_a); end
        n_vec++; if (pread_a !== 1'b0) begin n_bad++; $display("FAIL rst_pmem_read got %b want 0", pread_a); end
        n_vec++; if (pwrite_a !== 1'b0) begin n_bad++; $display("FAIL rst_pmem_write got %b want 0", pwrite_a); end
        n_vec++; if (paddr_a !== 16'h0) begin n_bad++; $display("FAIL rst_pmem_address got %h want 0", paddr_a); end
        n_vec++; if (pwdata_a !== 128'h0) begin n_bad++; $display("FAIL rst_pmem_wdata got %h want 0", pwdata_a); end
        n_vec++; if (hit_a !== 16'h0 || miss_a !== 16'h0) begin n_bad++; $display("FAIL rst_counters got %h/%h want 0/0", hit_a, miss_a); end
        n_vec++; if (state_a !== IDLE) begin n_bad++; $display("FAIL rst_state got %0d want IDLE", state_a); end
        n_vec++; if (hit_b !== 4'h0 || miss_b !== 4'h0) begin n_bad++; $display("FAIL rst_counters_b got %h/%h want 0/0", hit_b, miss_b); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_miss();
        logic [15:0] q; int lat; int f0;
        f0 = fill_a;
        cpu_access(0, 16'h1234, 0, 2'b11, 16'h0, q, lat);
        n_vec++; if (q !== 16'h1232) begin n_bad++; $display("FAIL miss_rdata got %h want 1232", q); end
        n_vec++; if (lat !== 4) begin n_bad++; $display("FAIL miss_latency got %0d want 4", lat); end
        n_vec++; if (fill_a - f0 !== 1 || wb_a !== 0) begin n_bad++; $display("FAIL miss_traffic fills %0d wbs %0d want 1/0", fill_a - f0, wb_a); end
        n_vec++; if (last_fill_a !== 16'h1230) begin n_bad++; $display("FAIL miss_fill_addr got %h want 1230", last_fill_a); end
        n_vec++; if (miss_a !== 16'd1 || hit_a !== 16'd1) begin n_bad++; $display("FAIL miss_counters got %0d/%0d want 1/1", miss_a, hit_a); end
        cpu_access(0, 16'h1236, 0, 2'b11, 16'h0, q, lat);
        n_vec++; if (q !== 16'h1233 || lat !== 1) begin n_bad++; $display("FAIL hit_read got %h lat %0d want 1233 lat 1", q, lat); end
    endtask

    task automatic test_write_hit();
        logic [15:0] q; int lat; lc3b_memband exp_line;
        cpu_access(0, 16'h1236, 1, 2'b10, 16'hBEEF, q, lat);
        n_vec++; if (lat !== 1) begin n_bad++; $display("FAIL write_hit_latency got %0d want 1", lat); end
        n_vec++; if (hit_a !== 16'd3 || miss_a !== 16'd1) begin n_bad++; $display("FAIL write_hit_counters got %0d/%0d want 3/1", hit_a, miss_a); end
        cpu_access(0, 16'h1236, 0, 2'b11, 16'h0, q, lat);
        n_vec++; if (q !== 16'hBE33) begin n_bad++; $display("FAIL write_merge got %h want be33", q); end
        cpu_access(0, 16'h1234, 0, 2'b11, 16'h0, q, lat);
        n_vec++; if (q !== 16'h1232) begin n_bad++; $display("FAIL write_neighbour got %h want 1232", q); end
        // Same set: 0x0030 takes the empty way, 0x00B0 then evicts dirty 0x1230.
        cpu_access(0, 16'h0030, 0, 2'b11, 16'h0, q, lat);
        cpu_access(0, 16'h00B0, 0, 2'b11, 16'h0, q, lat);
        exp_line = line_of(16'h1230);
        exp_line[63:48] = 16'hBE33;
        n_vec++; if (wb_a !== 1 || last_wb_a !== 16'h1230) begin n_bad++; $display("FAIL dirty_wb count %0d addr %h want 1 1230", wb_a, last_wb_a); end
        n_vec++; if (wb_data_a !== exp_line) begin n_bad++; $display("FAIL dirty_wb_data got %h want %h", wb_data_a, exp_line); end
        n_vec++; if (last_fill_a !== 16'h00B0 || miss_a !== 16'd3) begin n_bad++; $display("FAIL evict_fill addr %h misses %0d want 00b0 3", last_fill_a, miss_a); end
    endtask

    task automatic test_four_way();
        logic [15:0] q; int lat; logic [15:0] a;
        for (int i = 0; i < 4; i++) begin
            a = 16'(i * 16'h0080);
            cpu_access(1, a, 0, 2'b11, 16'h0, q, lat);
            n_vec++; if (q !== a || lat !== 4) begin n_bad++; $display("FAIL four_way_fill%0d got %h lat %0d want %h lat 4", i, q, lat, a); end
        end
        n_vec++; if (fill_b !== 4 || wb_b !== 0) begin n_bad++; $display("FAIL four_way_traffic fills %0d wbs %0d want 4/0", fill_b, wb_b); end
        for (int i = 0; i < 4; i++) begin
            cpu_access(1, 16'(i * 16'h0080), 0, 2'b11, 16'h0, q, lat);
            n_vec++; if (lat !== 1) begin n_bad++; $display("FAIL four_way_rehit%0d lat %0d want 1", i, lat); end
        end
        // PLRU after touching ways 0..3 in order points at way 0 (0x0000).
        cpu_access(1, 16'h0200, 0, 2'b11, 16'h0, q, lat);
        n_vec++; if (fill_b !== 5 || wb_b !== 0) begin n_bad++; $display("FAIL four_way_evict fills %0d wbs %0d want 5/0", fill_b, wb_b); end
        cpu_access(1, 16'h0080, 0, 2'b11, 16'h0, q, lat);
        n_vec++; if (lat !== 1) begin n_bad++; $display("FAIL four_way_kept lat %0d want 1", lat); end
        cpu_access(1, 16'h0000, 0, 2'b11, 16'h0, q, lat);
        n_vec++; if (lat !== 4) begin n_bad++; $display("FAIL four_way_victim lat %0d want 4", lat); end
        n_vec++; if (miss_b !== 4'd6 || hit_b !== 4'd11) begin n_bad++; $display("FAIL four_way_counters got %0d/%0d want 6/11", miss_b, hit_b); end
    endtask

    task automatic test_saturation();
        logic [15:0] q; int lat;
        for (int i = 0; i < 12; i++)
            cpu_access(1, 16'(16'h1000 + i * 16'h0080), 0, 2'b11, 16'h0, q, lat);
        n_vec++; if (miss_b !== 4'hF) begin n_bad++; $display("FAIL miss_saturate got %h want f", miss_b); end
        n_vec++; if (hit_b !== 4'hF) begin n_bad++; $display("FAIL hit_saturate got %h want f", hit_b); end
    endtask

    task automatic test_plru_evict();
        logic [15:0] q; int lat;
        sel = 0;
        apply_reset();
        cpu_access(0, 16'h0000, 0, 2'b11, 16'h0, q, lat);
        cpu_access(0, 16'h0080, 1, 2'b11, 16'h5555, q, lat);
        n_vec++; if (lat !== 4) begin n_bad++; $display("FAIL write_miss_latency got %0d want 4", lat); end
        cpu_access(0, 16'h0000, 0, 2'b11, 16'h0, q, lat);
        ev_q.delete();
        cpu_access(0, 16'h0100, 0, 2'b11, 16'h0, q, lat);
        n_vec++; if (ev_q.size() !== 2) begin n_bad++; $display("FAIL plru_events got %0d want 2", ev_q.size()); end
        else begin
            n_vec++; if (ev_q[0] !== {1'b1, 16'h0080}) begin n_bad++; $display("FAIL plru_wb_first got %h want 10080", ev_q[0]); end
            n_vec++; if (ev_q[1] !== {1'b0, 16'h0100}) begin n_bad++; $display("FAIL plru_fill_second got %h want 00100", ev_q[1]); end
        end
        n_vec++; if (wb_data_a[15:0] !== 16'h5555) begin n_bad++; $display("FAIL plru_wb_data got %h want 5555", wb_data_a[15:0]); end
        n_vec++; if (q !== 16'h0100 || lat !== 7) begin n_bad++; $display("FAIL plru_refill got %h lat %0d want 0100 lat 7", q, lat); end
        cpu_access(0, 16'h0000, 0, 2'b11, 16'h0, q, lat);
        n_vec++; if (lat !== 1) begin n_bad++; $display("FAIL plru_mru_kept lat %0d want 1", lat); end
        n_vec++; if (miss_a !== 16'd3 || hit_a !== 16'd5) begin n_bad++; $display("FAIL plru_counters got %0d/%0d want 3/5", miss_a, hit_a); end
    endtask

    task automatic test_reset_mid_fill();
        logic [15:0] q; int lat; int f0; int waited;
        sel = 0; stall = 1; addr = 16'h2000; be = 2'b11; rd = 1;
        waited = 0;
        while (!pread_a && waited < 20) begin @(negedge clk); waited++; end
        n_vec++; if (pread_a !== 1'b1) begin n_bad++; $display("FAIL midfill_pmem_read got %b want 1", pread_a); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++; if (pread_a !== 1'b0 || paddr_a !== 16'h0) begin n_bad++; $display("FAIL midfill_drop read %b addr %h want 0 0000", pread_a, paddr_a); end
        rd = 0; stall = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        f0 = fill_a;
        cpu_access(0, 16'h2000, 0, 2'b11, 16'h0, q, lat);
        n_vec++; if (lat !== 4 || fill_a - f0 !== 1) begin n_bad++; $display("FAIL midfill_remiss lat %0d fills %0d want 4 1", lat, fill_a - f0); end
        n_vec++; if (q !== 16'h2000 || miss_a !== 16'd1) begin n_bad++; $display("FAIL midfill_result got %h misses %0d want 2000 1", q, miss_a); end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_write_hit();
        test_four_way();
        test_saturation();
        test_plru_evict();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
